// File: rtl/div_arbiter_if.sv
// Request/response bundle between four requesters, the arbiter and the shared divider.
// The slave side is the arbiter; the master side is its environment.
interface div_arbiter_if;
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [3:0]  q;
    logic [3:0]  r;
    logic        err;
    logic        div_start;
    logic [3:0]  div_a;
    logic [3:0]  div_b;
    logic        div_done;
    logic [3:0]  div_q;
    logic [3:0]  div_r;

    modport slave (
        input  req, a, b, div_done, div_q, div_r,
        output gnt, ack, q, r, err, div_start, div_a, div_b
    );

    modport master (
        output req, a, b, div_done, div_q, div_r,
        input  gnt, ack, q, r, err, div_start, div_a, div_b
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one iterative 4-bit divider among four requesters.
// Latches the winner's operands, starts the divider and returns its result with an ack.
module div_arbiter #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    div_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, GRANT, START, WAIT_CLR, WAIT_DONE, RESP
    } state_e;

    localparam logic [4:0] CntLast = 5'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] ack_q, ack_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic [3:0] da_q, da_d;
    logic [3:0] db_q, db_d;
    logic       err_q, err_d;
    logic       start_q, start_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win_q, win_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] pick;
    logic       found;

    // first set request after the last winner, wrapping modulo 4
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && bus.req[ptr_q + 2'(i)]) begin
                found = 1'b1;
                pick  = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        q_d     = q_q;
        r_d     = r_q;
        da_d    = da_q;
        db_d    = db_q;
        err_d   = err_q;
        start_d = 1'b0;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    da_d    = bus.a[{pick, 2'b00} +: 4];
                    db_d    = bus.b[{pick, 2'b00} +: 4];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CntLast) begin
                    q_d     = 4'hF;
                    r_d     = 4'hF;
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = RESP;
                end else if (!bus.div_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 5'd1;
                if (bus.div_done) begin
                    q_d     = bus.div_q;
                    r_d     = bus.div_r;
                    err_d   = 1'b0;
                    ack_d   = gnt_q;
                    state_d = RESP;
                end else if (cnt_q == CntLast) begin
                    q_d     = 4'hF;
                    r_d     = 4'hF;
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                gnt_d   = '0;
                ack_d   = '0;
                err_d   = 1'b0;
                da_d    = '0;
                db_d    = '0;
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            da_q    <= '0;
            db_q    <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            ptr_q   <= 2'd3;
            win_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            r_q     <= r_d;
            da_q    <= da_d;
            db_q    <= db_d;
            err_q   <= err_d;
            start_q <= start_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.q         = q_q;
    assign bus.r         = r_q;
    assign bus.err       = err_q;
    assign bus.div_start = start_q;
    assign bus.div_a     = da_q;
    assign bus.div_b     = db_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: divider stub, transaction-level reference model,
// per-cycle comparison and directed scenarios with literal expectations.
module tb_div_arbiter;
    localparam int TO = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_arbiter_if bus ();

    div_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int nstart = 0;
    int start_cyc = 0;
    bit hold_req = 0;
    int mode = 0;

    // divider stub: mode 0 normal, 1 stale done for 3 cycles, 2 never done
    logic       st_done = 1'b0;
    logic [3:0] st_q = '0, st_r = '0, st_a = '0, st_b = '0;
    int         st_hold = 0, st_lat = 0;
    bit         st_act = 0;

    always @(posedge clk) begin
        if (bus.div_start) begin
            st_a    <= bus.div_a;
            st_b    <= bus.div_b;
            st_done <= (mode == 1);
            st_hold <= (mode == 1) ? 3 : 0;
            st_lat  <= (mode == 1) ? 2 : 3;
            st_act  <= (mode != 2);
        end else if (st_hold > 0) begin
            st_hold <= st_hold - 1;
            if (st_hold == 1) st_done <= 1'b0;
        end else if (st_act) begin
            if (st_lat > 1) begin
                st_lat <= st_lat - 1;
            end else begin
                st_done <= 1'b1;
                st_act  <= 0;
                st_q    <= (st_b == 0) ? 4'hF : st_a / st_b;
                st_r    <= (st_b == 0) ? 4'hF : st_a % st_b;
            end
        end
    end

    assign bus.div_done = st_done;
    assign bus.div_q    = st_q;
    assign bus.div_r    = st_r;

    // reference model: elapsed-edge count since grant drives the expected outputs
    logic [3:0] exp_gnt = '0, exp_ack = '0, exp_q = '0, exp_r = '0;
    logic [3:0] exp_da = '0, exp_db = '0;
    logic       exp_err = 1'b0, exp_start = 1'b0;
    int         m_ptr = 3, m_win = 0, m_el = 0;
    bit         m_busy = 0, m_resp = 0, m_low = 0;
    logic [3:0] m_a = '0, m_b = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_gnt = '0; exp_ack = '0; exp_q = '0; exp_r = '0;
            exp_da = '0; exp_db = '0; exp_err = 1'b0; exp_start = 1'b0;
            m_ptr = 3; m_busy = 0; m_resp = 0;
        end else if (m_resp) begin
            exp_gnt = '0; exp_ack = '0; exp_err = 1'b0;
            exp_da = '0; exp_db = '0;
            m_ptr = m_win; m_busy = 0; m_resp = 0;
        end else if (!m_busy) begin
            for (int i = 1; i <= 4; i++) begin
                if (!m_busy && bus.req[(m_ptr + i) % 4]) begin
                    m_win = (m_ptr + i) % 4;
                    m_busy = 1;
                end
            end
            if (m_busy) begin
                m_a = bus.a[4*m_win +: 4];
                m_b = bus.b[4*m_win +: 4];
                exp_gnt = 4'b0001 << m_win;
                exp_da = m_a;
                exp_db = m_b;
                m_el = 0;
                m_low = 0;
            end
        end else begin
            m_el++;
            if (m_el == 1) begin
                exp_start = 1'b1;
            end else if (m_el == 2) begin
                exp_start = 1'b0;
            end else if (m_low && bus.div_done) begin
                exp_ack = exp_gnt;
                exp_q = (m_b == 0) ? 4'hF : m_a / m_b;
                exp_r = (m_b == 0) ? 4'hF : m_a % m_b;
                exp_err = 1'b0;
                m_resp = 1;
            end else if (m_el - 3 == TO - 1) begin
                exp_ack = exp_gnt;
                exp_q = 4'hF;
                exp_r = 4'hF;
                exp_err = 1'b1;
                m_resp = 1;
            end else if (!bus.div_done) begin
                m_low = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("gnt", bus.gnt, exp_gnt);
        chk("ack", bus.ack, exp_ack);
        chk("err", bus.err, exp_err);
        chk("div_start", bus.div_start, exp_start);
        chk("div_a", bus.div_a, exp_da);
        chk("div_b", bus.div_b, exp_db);
        if (exp_ack != 0) begin
            chk("q", bus.q, exp_q);
            chk("r", bus.r, exp_r);
        end
        if (bus.div_start) begin
            nstart++;
            start_cyc = cyc;
        end
        if (!hold_req) bus.req = bus.req & ~bus.ack;
    endtask

    task automatic wait_ack(input string nm, input logic [3:0] ea,
                            input logic [3:0] eq, input logic [3:0] er,
                            input logic ee, output int lat);
        int n = 0;
        lat = -1;
        while (bus.ack == 0 && n < 200) begin
            tick();
            n++;
        end
        if (bus.ack == 0) begin
            chk({nm, "_ack_wait"}, 0, 1);
        end else begin
            lat = cyc - start_cyc;
            chk({nm, "_ack"}, bus.ack, ea);
            chk({nm, "_q"}, bus.q, eq);
            chk({nm, "_r"}, bus.r, er);
            chk({nm, "_err"}, bus.err, ee);
            chk({nm, "_model_q"}, exp_q, eq);
            chk({nm, "_model_r"}, exp_r, er);
        end
        tick();
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        bus.req = '0;
        bus.a = '0;
        bus.b = '0;

        do_reset();
        chk("reset_gnt", bus.gnt, 0);
        chk("reset_ack", bus.ack, 0);
        chk("reset_q", bus.q, 0);
        chk("reset_div_a", bus.div_a, 0);

        nstart = 0;
        bus.a = 16'h000D;
        bus.b = 16'h0004;
        bus.req = 4'b0001;
        tick();
        tick();
        bus.a = 16'h0FFF;
        bus.b = 16'h0FF2;
        wait_ack("single", 4'b0001, 4'd3, 4'd1, 1'b0, lat);
        chk("single_lat", lat, 5);
        chk("single_starts", nstart, 1);
        chk("single_gnt_drop", bus.gnt, 0);

        do_reset();
        bus.a = 16'hF379;
        bus.b = 16'h1572;
        bus.req = 4'b1111;
        wait_ack("all0", 4'b0001, 4'd4, 4'd1, 1'b0, lat);
        wait_ack("all1", 4'b0010, 4'd1, 4'd0, 1'b0, lat);
        wait_ack("all2", 4'b0100, 4'd0, 4'd3, 1'b0, lat);
        wait_ack("all3", 4'b1000, 4'd15, 4'd0, 1'b0, lat);

        do_reset();
        bus.a = 16'h0508;
        bus.b = 16'h0302;
        hold_req = 1;
        bus.req = 4'b0101;
        wait_ack("rr0", 4'b0001, 4'd4, 4'd0, 1'b0, lat);
        wait_ack("rr1", 4'b0100, 4'd1, 4'd2, 1'b0, lat);
        wait_ack("rr2", 4'b0001, 4'd4, 4'd0, 1'b0, lat);
        bus.req = 4'b0100;
        hold_req = 0;
        wait_ack("rr3", 4'b0100, 4'd1, 4'd2, 1'b0, lat);

        do_reset();
        bus.a = 16'h0600;
        bus.b = 16'h0000;
        bus.req = 4'b0100;
        wait_ack("div0", 4'b0100, 4'hF, 4'hF, 1'b0, lat);

        do_reset();
        mode = 1;
        bus.a = 16'h00B0;
        bus.b = 16'h0030;
        bus.req = 4'b0010;
        wait_ack("stale", 4'b0010, 4'd3, 4'd2, 1'b0, lat);
        chk("stale_lat", lat, 7);

        do_reset();
        mode = 2;
        bus.a = 16'h5000;
        bus.b = 16'h1000;
        bus.req = 4'b1000;
        wait_ack("timeout", 4'b1000, 4'hF, 4'hF, 1'b1, lat);
        chk("timeout_lat", lat, TO + 1);

        do_reset();
        mode = 2;
        bus.a = 16'h000A;
        bus.b = 16'h0003;
        bus.req = 4'b0001;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_gnt", bus.gnt, 0);
        chk("midrst_ack", bus.ack, 0);
        chk("midrst_div_a", bus.div_a, 0);
        rst_n = 1'b1;
        mode = 0;
        wait_ack("rerun", 4'b0001, 4'd3, 4'd1, 1'b0, lat);
        chk("rerun_lat", lat, 5);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
